// File: rtl/rd_sched_pkg.sv
// Shared types and default parameter values for the rd_sched read scheduler.
package rd_sched_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    IDLE  = 2'd1,
    BURST = 2'd2
  } rd_sched_state_t;

  localparam int unsigned DEF_BOOT_RD_CYCLES = 2;
  localparam int unsigned DEF_ADDR_W         = 8;
  localparam int unsigned DEF_LEN_W          = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic; purely combinational, the pointer lives in the caller.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/rd_sched.sv
// Read scheduler: boot read burst after reset, then round-robin multi-cycle bursts
// for two requesters on a single-port read resource. All outputs registered.
module rd_sched
  import rd_sched_pkg::*;
#(
  parameter int unsigned BOOT_RD_CYCLES = DEF_BOOT_RD_CYCLES,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned LEN_W          = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  output logic [1:0]        gnt,
  output logic              rd,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        done,
  output logic              busy
);

  localparam int unsigned BC_W = $clog2(BOOT_RD_CYCLES + 1);

  rd_sched_state_t   state_q, state_d;
  logic [BC_W-1:0]   boot_cnt_q, boot_cnt_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic              busy_q, busy_d;
  logic [1:0]        arb_gnt;

  rr_arb2 u_arb (
    .req  (req),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    rd_d       = 1'b0;
    rd_addr_d  = rd_addr_q;
    gnt_d      = gnt_q;
    done_d     = '0;

    unique case (state_q)
      BOOT: begin
        gnt_d = '0;
        if (boot_cnt_q < BC_W'(BOOT_RD_CYCLES)) begin
          rd_d       = 1'b1;
          rd_addr_d  = ADDR_W'(boot_cnt_q);
          boot_cnt_d = boot_cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          gnt_d     = arb_gnt;
          rd_d      = 1'b1;
          rd_addr_d = arb_gnt[1] ? addr1 : addr0;
          cnt_d     = arb_gnt[1] ? len1 : len0;
          state_d   = BURST;
        end
      end
      BURST: begin
        // Counter value 0 marks the read already on the port as the final one.
        if (cnt_q == '0) begin
          gnt_d   = '0;
          done_d  = gnt_q;
          last_d  = gnt_q[1];
          state_d = IDLE;
        end else begin
          rd_d      = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          cnt_d     = cnt_q - 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = BOOT;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      rd_q       <= 1'b0;
      rd_addr_q  <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      rd_q       <= rd_d;
      rd_addr_q  <= rd_addr_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign rd      = rd_q;
  assign rd_addr = rd_addr_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rd_sched.sv
// Scoreboard bench for rd_sched: the driver predicts each read/done from the
// arbitration rules and queues it; a negedge monitor pops and compares.
module tb_rd_sched;

  localparam int unsigned BOOT = 2;
  localparam int unsigned AW   = 8;
  localparam int unsigned LW   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [AW-1:0] addr0, addr1;
  logic [LW-1:0] len0, len1;
  logic [1:0]    gnt;
  logic          rd;
  logic [AW-1:0] rd_addr;
  logic [1:0]    done;
  logic          busy;

  always #5 clk = ~clk;

  rd_sched #(
    .BOOT_RD_CYCLES (BOOT),
    .ADDR_W         (AW),
    .LEN_W          (LW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .addr0   (addr0),
    .addr1   (addr1),
    .len0    (len0),
    .len1    (len1),
    .gnt     (gnt),
    .rd      (rd),
    .rd_addr (rd_addr),
    .done    (done),
    .busy    (busy)
  );

  typedef struct {
    logic [1:0]    gnt;
    logic [AW-1:0] addr;
    bit            last;
    logic [1:0]    done;
  } exp_t;

  exp_t        rdq[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic push_read(input logic [1:0] g, input logic [AW-1:0] a, input bit l,
                           input logic [1:0] d);
    exp_t e;
    e.gnt = g; e.addr = a; e.last = l; e.done = d;
    rdq.push_back(e);
  endtask

  // Reset (optionally with requests pending), release, and wait to the IDLE sample cycle.
  task automatic reset_seq(input logic [1:0] boot_req);
    rst = 1'b1;
    req = boot_req;
    rdq.delete();
    m_last = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    for (int i = 0; i < int'(BOOT); i++)
      push_read(2'b00, AW'(i), i == int'(BOOT) - 1, 2'b00);
    repeat (BOOT + 1) @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at a negedge of an IDLE cycle; returns at the negedge of the done cycle.
  task automatic round(input logic [1:0] newreq, input bit keep, input bit rnd);
    logic [1:0]    r;
    int            w;
    int            len;
    logic [AW-1:0] base;
    logic [1:0]    g;
    r = req | newreq;
    if (r == 2'b00) begin
      newreq = 2'b01;
      r      = 2'b01;
    end
    if (rnd && newreq[0] && !req[0]) begin addr0 = AW'($urandom); len0 = LW'($urandom); end
    if (rnd && newreq[1] && !req[1]) begin addr1 = AW'($urandom); len1 = LW'($urandom); end
    req = r;
    if (r == 2'b01)      w = 0;
    else if (r == 2'b10) w = 1;
    else                 w = m_last ? 0 : 1;
    base = (w == 1) ? addr1 : addr0;
    len  = (w == 1) ? int'(len1) : int'(len0);
    g    = 2'(1 << w);
    for (int k = 0; k <= len; k++)
      push_read(g, base + AW'(k), k == len, g);
    @(posedge clk);
    #1 chk("gnt_latency", 32'(gnt), 32'(g));
    if (!keep) begin
      req[w] = 1'b0;
      if (w == 1) begin addr1 = AW'($urandom); len1 = LW'($urandom); end
      else        begin addr0 = AW'($urandom); len0 = LW'($urandom); end
    end
    m_last = (w == 1);
    repeat (len + 1) @(posedge clk);
    @(negedge clk);
  endtask

  bit   after_last = 1'b0;
  bit   cont       = 1'b0;
  logic [1:0] exp_done;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      after_last = 1'b0;
      cont       = 1'b0;
    end else if (after_last) begin
      chk("gap_rd", 32'(rd), 32'd0);
      chk("gap_gnt", 32'(gnt), 32'd0);
      chk("done_pulse", 32'(done), 32'(exp_done));
      chk("gap_busy", 32'(busy), 32'd0);
      after_last = 1'b0;
    end else begin
      chk("done_quiet", 32'(done), 32'd0);
      if (rd) begin
        if (rdq.size() == 0) begin
          chk("rd_unexpected", 32'(rd), 32'd0);
        end else begin
          mon_e = rdq.pop_front();
          chk("rd_gnt", 32'(gnt), 32'(mon_e.gnt));
          chk("rd_addr", 32'(rd_addr), 32'(mon_e.addr));
          chk("rd_busy", 32'(busy), 32'd1);
          if (mon_e.last) begin
            after_last = 1'b1;
            exp_done   = mon_e.done;
            cont       = 1'b0;
          end else begin
            cont = 1'b1;
          end
        end
      end else if (cont) begin
        chk("rd_missing", 32'(rd), 32'd1);
        cont = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    req = '0; addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    reset_seq(2'b00);

    addr0 = 8'h40; addr1 = 8'h80; len0 = '0; len1 = '0;
    for (int i = 0; i < 4; i++) round(2'b11, 1'b1, 1'b0);
    req = 2'b00;
    @(negedge clk);

    addr0 = 8'h10; len0 = 3'd3;
    round(2'b01, 1'b0, 1'b0);

    addr1 = 8'hFE; len1 = 3'd2;
    round(2'b10, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) round(2'($urandom_range(0, 3)), 1'b0, 1'b1);

    addr1 = 8'h5A; len1 = 3'd1;
    reset_seq(2'b10);
    round(2'b00, 1'b0, 1'b0);

    req = 2'b01; addr0 = 8'h30; len0 = 3'd5;
    push_read(2'b01, 8'h30, 1'b0, 2'b00);
    @(posedge clk);
    #1 chk("abort_gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    req = 2'b00;
    #1;
    chk("abort_rd", 32'(rd), 32'd0);
    chk("abort_gnt_clr", 32'(gnt), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    reset_seq(2'b00);

    addr0 = 8'h20; addr1 = 8'h21; len0 = 3'd1; len1 = 3'd2;
    round(2'b11, 1'b0, 1'b0);
    round(2'b00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(rdq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
